// File: rtl/neopixel_pkg.sv
// Shared types and default 125 MHz timing for the WS2812 pixel driver.
package neopixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int PIXEL_W = 24;

    localparam int DEF_PIXELS = 12;
    localparam int DEF_T0H    = 50;
    localparam int DEF_T1H    = 100;
    localparam int DEF_TBIT   = 156;
    localparam int DEF_TRESET = 6250;

    // GRB field offsets inside a 24-bit pixel word
    localparam int G_OFS = 16;
    localparam int R_OFS = 8;
    localparam int B_OFS = 0;

endpackage

// File: rtl/neopixel_bit_timer.sv
// One WS2812 bit slot: C_TBIT cycles, high for C_T1H (bit=1) or C_T0H (bit=0) cycles.
module neopixel_bit_timer
    import neopixel_pkg::*;
#(
    parameter int C_T0H  = DEF_T0H,
    parameter int C_T1H  = DEF_T1H,
    parameter int C_TBIT = DEF_TBIT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic enable,
    input  logic bit_val,
    output logic high,
    output logic last_cycle
);

    localparam int CNT_W = $clog2(C_TBIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_TBIT - 1);
    localparam logic [CNT_W-1:0] TH_ONE  = CNT_W'(C_TBIT - C_T1H);
    localparam logic [CNT_W-1:0] TH_ZERO = CNT_W'(C_TBIT - C_T0H);

    logic [CNT_W-1:0] cnt;

    // Free-running slot counter: reloads itself at terminal count so bits abut
    always_ff @(posedge clock) begin
        if (reset || start) begin
            cnt <= CNT_MAX;
        end else if (enable) begin
            cnt <= (cnt == '0) ? CNT_MAX : cnt - 1'b1;
        end
    end

    assign last_cycle = enable && (cnt == '0);
    assign high       = enable && (cnt >= (bit_val ? TH_ONE : TH_ZERO));

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 pixel driver: frame buffer with register-style access and serial output.
// Build option NEOPIXEL_CONTINUOUS_EN: refresh frames back-to-back regardless of writes.
module neopixel_driver
    import neopixel_pkg::*;
#(
    parameter int C_PIXELS = DEF_PIXELS,
    parameter int C_T0H    = DEF_T0H,
    parameter int C_T1H    = DEF_T1H,
    parameter int C_TBIT   = DEF_TBIT,
    parameter int C_TRESET = DEF_TRESET
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        dout
);

    // state | meaning
    // IDLE  | buffer accessible, ready high, waiting for dirty
    // LOAD  | snapshot pixel 0 into the shift register
    // SEND  | serialise all pixels MSB first
    // LATCH | hold dout low for the latch gap

    localparam int IDX_W = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
    localparam int BIT_W = $clog2(PIXEL_W);
    localparam int LAT_W = $clog2(C_TRESET);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_PIXELS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_W - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(C_TRESET - 1);

    state_t state, next_state;

    logic [PIXEL_W-1:0] pixel_mem [C_PIXELS];
    logic [PIXEL_W-1:0] shift_reg;
    logic [IDX_W-1:0]   pix_idx;
    logic [BIT_W-1:0]   bit_cnt;
    logic [LAT_W-1:0]   latch_cnt;
    logic               dirty;
    logic               addr_ok, write_ok, frame_done;
    logic               bt_high, bt_last;
    logic [IDX_W-1:0]   addr_idx;
    logic               unused_hi;

    assign addr_ok    = (address < 32'(C_PIXELS));
    assign addr_idx   = address[IDX_W-1:0];
    assign write_ok   = write_en && ready && addr_ok;
    assign frame_done = bt_last && (bit_cnt == '0) && (pix_idx == LAST_IDX);
    assign unused_hi  = ^write_data[31:PIXEL_W];

    neopixel_bit_timer #(
        .C_T0H (C_T0H),
        .C_T1H (C_T1H),
        .C_TBIT(C_TBIT)
    ) u_bit_timer (
        .clock     (clock),
        .reset     (reset),
        .start     (state == LOAD),
        .enable    (state == SEND),
        .bit_val   (shift_reg[PIXEL_W-1]),
        .high      (bt_high),
        .last_cycle(bt_last)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
`ifdef NEOPIXEL_CONTINUOUS_EN
            IDLE:  next_state = LOAD;
`else
            IDLE:  if (dirty) next_state = LOAD;
`endif
            LOAD:  next_state = SEND;
            SEND:  if (frame_done) next_state = LATCH;
            LATCH: if (latch_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < C_PIXELS; i++) pixel_mem[i] <= '0;
            shift_reg <= '0;
            pix_idx   <= '0;
            bit_cnt   <= '0;
            latch_cnt <= '0;
            dirty     <= 1'b0;
            ready     <= 1'b0;
            dout      <= 1'b0;
            read_data <= '0;
        end else begin
            // ready mirrors the state register, so it is high exactly while in IDLE
            ready     <= (next_state == IDLE);
            dout      <= bt_high;
            read_data <= addr_ok ? {8'h00, pixel_mem[addr_idx]} : '0;
            if (write_ok) begin
                pixel_mem[addr_idx] <= write_data[PIXEL_W-1:0];
                dirty               <= 1'b1;
            end
            case (state)
                LOAD: begin
                    dirty     <= 1'b0;
                    pix_idx   <= '0;
                    shift_reg <= pixel_mem[0];
                    bit_cnt   <= LAST_BIT;
                end
                SEND: begin
                    if (bt_last) begin
                        if (bit_cnt != '0) begin
                            shift_reg <= {shift_reg[PIXEL_W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt - 1'b1;
                        end else if (pix_idx != LAST_IDX) begin
                            pix_idx   <= pix_idx + 1'b1;
                            shift_reg <= pixel_mem[pix_idx + 1'b1];
                            bit_cnt   <= LAST_BIT;
                        end else begin
                            latch_cnt <= LAT_MAX;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt != '0) latch_cnt <= latch_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_driver.sv
// Directed and randomised checks of neopixel_driver against a frame-level reference model.
module tb_neopixel_driver;

    localparam int P      = 12;
    localparam int T0H    = 3;
    localparam int T1H    = 6;
    localparam int TBIT   = 10;
    localparam int TRESET = 40;
    localparam int NBITS  = P * 24;
    localparam int FRAME_LEN = 1 + NBITS * TBIT + TRESET;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic        dout;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] model [P];

    neopixel_driver #(
        .C_PIXELS(P),
        .C_T0H   (T0H),
        .C_T1H   (T1H),
        .C_TBIT  (TBIT),
        .C_TRESET(TRESET)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .write_en  (write_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .dout      (dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic accept;
        accept = (ready === 1'b1) && (a < P);
        address = a;
        write_data = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        if (accept) model[a] = d[23:0];
    endtask

    task automatic read_check(input string tag, input logic [31:0] a);
        logic [31:0] exp;
        exp = '0;
        if (a < P) exp = {8'h00, model[a]};
        address = a;
        tick();
        check(tag, read_data, exp);
    endtask

    task automatic no_frame_check(input string tag, input int cycles);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ready !== 1'b1 || dout !== 1'b0) saw = 1'b1;
        end
        check(tag, 32'(saw), 32'd0);
    endtask

    // Turn sampled dout into pulses and compare each bit against the buffer model
    task automatic decode(input string tag, input bit q[$]);
        int rises[$];
        int highs[$];
        int len, k_max, bitv;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] && (i == 0 || !q[i-1])) begin
                len = 0;
                for (int j = i; j < q.size() && q[j]; j++) len++;
                rises.push_back(i);
                highs.push_back(len);
            end
        end
        check({tag, " pulses"}, 32'(rises.size()), 32'(NBITS));
        k_max = (rises.size() < NBITS) ? rises.size() : NBITS;
        for (int k = 0; k < k_max; k++) begin
            bitv = int'(model[k / 24][23 - (k % 24)]);
            check($sformatf("%s bit%0d high", tag, k), 32'(highs[k]), 32'(bitv != 0 ? T1H : T0H));
            if (k > 0) check($sformatf("%s bit%0d period", tag, k), 32'(rises[k] - rises[k-1]), 32'(TBIT));
        end
    endtask

    task automatic capture_frame(input string tag, input int inject_at,
                                 input logic [31:0] inj_addr, input logic [31:0] inj_data);
        bit q[$];
        int n, w;
        w = 0;
        while (ready === 1'b1 && w < 10) begin
            tick();
            w++;
        end
        check({tag, " start"}, 32'(ready), 32'd0);
        n = 0;
        q.push_back(dout);
        while (ready !== 1'b1 && n < FRAME_LEN + 50) begin
            if (n == inject_at) begin
                address = inj_addr;
                write_data = inj_data;
                write_en = 1'b1;
            end else begin
                write_en = 1'b0;
            end
            tick();
            n++;
            q.push_back(dout);
        end
        write_en = 1'b0;
        check({tag, " length"}, 32'(n), 32'(FRAME_LEN));
        decode(tag, q);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [23:0] old;
        int w;

        for (int i = 0; i < P; i++) model[i] = '0;

        repeat (3) tick();
        check("reset ready", 32'(ready), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check("reset read_data", read_data, 32'd0);
        reset = 1'b0;
        tick();
        check("ready after reset", 32'(ready), 32'd1);
        read_check("read0 after reset", 0);

        // first frame: pixel 0 = 04/02/01
        do_write(0, 32'h00040201);
        check("ready after write", 32'(ready), 32'd1);
        tick();
        check("ready low 2 cycles after write", 32'(ready), 32'd0);
        capture_frame("frame1", -1, '0, '0);
        check("ready after frame1", 32'(ready), 32'd1);

        do_write(5, 32'h00FF00FF);
        capture_frame("frame2", -1, '0, '0);
        read_check("read5", 5);
        read_check("read12", 12);

        // same-cycle read and write of one address
        old = model[5];
        address = 5;
        write_data = 32'h00123456;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        check("rw old value", read_data, {8'h00, old});
        model[5] = 24'h123456;
        tick();
        check("rw new value", read_data, 32'h00123456);
        capture_frame("frame_rw", -1, '0, '0);

        // out-of-range write starts nothing
        do_write(12, 32'h00ABCDEF);
        no_frame_check("oor no frame", 20);
        read_check("read12 after oor write", 12);
        read_check("read0 after oor write", 0);

        // write during SEND is dropped
        do_write(3, 32'h00A5C3F0);
        capture_frame("frame3", -1, '0, '0);
        do_write(1, $urandom);
        capture_frame("frame4", 500, 3, 32'h00111111);
        read_check("pixel3 kept", 3);
        no_frame_check("dropped write no frame", 20);
        do_write(7, $urandom);
        capture_frame("frame5", -1, '0, '0);

        for (int r = 0; r < 5; r++) begin
            a = $urandom_range(0, 13);
            d = $urandom;
            do_write(a, d);
            if (a < P) capture_frame($sformatf("rand%0d", r), -1, '0, '0);
            else no_frame_check($sformatf("rand%0d no frame", r), 10);
            read_check($sformatf("rand%0d read", r), a);
        end

        // reset in the middle of pixel 4
        do_write(4, 32'h00FFFFFF);
        capture_frame("frame_p4", -1, '0, '0);
        do_write(9, $urandom);
        w = 0;
        while (ready === 1'b1 && w < 10) begin
            tick();
            w++;
        end
        check("pre-reset frame start", 32'(ready), 32'd0);
        repeat ((4 * 24 + 10) * TBIT + 4) tick();
        reset = 1'b1;
        tick();
        check("dout after mid reset", 32'(dout), 32'd0);
        check("ready during mid reset", 32'(ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < P; i++) model[i] = '0;
        tick();
        check("ready after mid reset", 32'(ready), 32'd1);
        for (int i = 0; i < P; i++) read_check($sformatf("cleared read%0d", i), i);
        no_frame_check("no frame after reset", 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
